// File: rtl/common_pkg.sv
// Shared pipeline types: thread count, thread id and virtual PC widths, and the
// per-thread fetch scheduling state.
package common;

    localparam int unsigned n_threads = 4;

    typedef logic [1:0]  threadid_t;
    typedef logic [31:0] vptr_t;

    typedef enum logic [1:0] {
        TS_READY,
        TS_WAIT_FILL,
        TS_WAIT_REDIRECT
    } sched_state_t;

endpackage

// File: rtl/thread_scheduler_rr_arbiter.sv
// Rotating-priority picker: grants the first requester after last_i, wrapping,
// as a one-hot vector. Purely combinational.
module rr_arbiter
    import common::*;
#(
    parameter int unsigned N = n_threads
) (
    input  logic [N-1:0] request_i,
    input  threadid_t    last_i,
    output logic [N-1:0] grant_o,
    output logic         grant_valid_o
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] idx;

    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        idx           = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = IW'((32'(last_i) + k) % N);
            if (!grant_valid_o && request_i[idx]) begin
                grant_o[idx]  = 1'b1;
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// Fetch-side thread scheduler: rotating-priority pick of one runnable thread per
// cycle, with per-thread park/replay/redirect tracking driven by IF and WB events.
module thread_scheduler
    import common::*;
#(
    parameter int unsigned N_THREADS = common::n_threads,
    parameter vptr_t       RESET_PC  = 32'h0000_1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_THREADS-1:0] thread_enable,
    input  logic                 stall,
    input  logic                 if_valid,
    input  threadid_t            if_thread,
    input  vptr_t                if_pc,
    input  logic                 if_icache_miss,
    input  logic                 if_itlb_miss,
    input  logic                 mem_fill_en,
    input  threadid_t            mem_fill_thread,
    input  logic                 wb_invalidate_en,
    input  threadid_t            wb_invalidate_thread,
    input  vptr_t                wb_redirect_pc,
    output logic                 fetch_valid,
    output threadid_t            fetch_thread,
    output vptr_t                fetch_pc
);

    sched_state_t state_q [N_THREADS];
    sched_state_t state_d [N_THREADS];
    vptr_t        pc_q    [N_THREADS];
    vptr_t        pc_d    [N_THREADS];
    threadid_t    last_q, last_d;
    logic         cool_v_q, cool_v_d;
    threadid_t    cool_q, cool_d;
    logic         fetch_valid_q, fetch_valid_d;
    threadid_t    fetch_thread_q, fetch_thread_d;
    vptr_t        fetch_pc_q, fetch_pc_d;

    logic [N_THREADS-1:0] request;
    logic [N_THREADS-1:0] grant;
    logic                 grant_valid;
    logic                 miss_hit, wb_hit;

    // A thread touched by a miss report or redirect this cycle must not issue from stale state.
    always_comb begin
        request  = '0;
        miss_hit = 1'b0;
        wb_hit   = 1'b0;
        for (int unsigned t = 0; t < N_THREADS; t++) begin
            miss_hit   = if_valid && (if_icache_miss || if_itlb_miss) && (if_thread == threadid_t'(t));
            wb_hit     = wb_invalidate_en && (wb_invalidate_thread == threadid_t'(t));
            request[t] = (state_q[t] == TS_READY) && thread_enable[t]
                         && !(cool_v_q && (cool_q == threadid_t'(t))) && !miss_hit && !wb_hit;
        end
    end

    rr_arbiter #(
        .N (N_THREADS)
    ) u_arb (
        .request_i     (request),
        .last_i        (last_q),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        last_d         = last_q;
        cool_v_d       = cool_v_q;
        cool_d         = cool_q;
        fetch_valid_d  = fetch_valid_q;
        fetch_thread_d = fetch_thread_q;
        fetch_pc_d     = fetch_pc_q;
        for (int unsigned t = 0; t < N_THREADS; t++) begin
            state_d[t] = state_q[t];
            pc_d[t]    = pc_q[t];
        end

        if (!stall) begin
            fetch_valid_d = grant_valid;
            cool_v_d      = grant_valid;
            for (int unsigned t = 0; t < N_THREADS; t++) begin
                if (grant[t]) begin
                    fetch_thread_d = threadid_t'(t);
                    fetch_pc_d     = pc_q[t];
                    pc_d[t]        = pc_q[t] + 32'd4;
                    last_d         = threadid_t'(t);
                    cool_d         = threadid_t'(t);
                end
            end
        end else if (wb_invalidate_en && fetch_valid_q && (wb_invalidate_thread == fetch_thread_q)) begin
            fetch_valid_d = 1'b0;
        end

        // Priority: redirect > ITLB miss > icache miss > fill.
        for (int unsigned t = 0; t < N_THREADS; t++) begin
            if (wb_invalidate_en && (wb_invalidate_thread == threadid_t'(t))) begin
                state_d[t] = TS_READY;
                pc_d[t]    = wb_redirect_pc;
            end else if (if_valid && if_itlb_miss && (if_thread == threadid_t'(t))) begin
                state_d[t] = TS_WAIT_REDIRECT;
            end else if (if_valid && if_icache_miss && (if_thread == threadid_t'(t))) begin
                state_d[t] = TS_WAIT_FILL;
                pc_d[t]    = if_pc;
            end else if (mem_fill_en && (mem_fill_thread == threadid_t'(t))
                         && (state_q[t] == TS_WAIT_FILL)) begin
                state_d[t] = TS_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned t = 0; t < N_THREADS; t++) begin
                state_q[t] <= TS_READY;
                pc_q[t]    <= RESET_PC;
            end
            last_q         <= threadid_t'(N_THREADS - 1);
            cool_v_q       <= 1'b0;
            cool_q         <= '0;
            fetch_valid_q  <= 1'b0;
            fetch_thread_q <= '0;
            fetch_pc_q     <= '0;
        end else begin
            for (int unsigned t = 0; t < N_THREADS; t++) begin
                state_q[t] <= state_d[t];
                pc_q[t]    <= pc_d[t];
            end
            last_q         <= last_d;
            cool_v_q       <= cool_v_d;
            cool_q         <= cool_d;
            fetch_valid_q  <= fetch_valid_d;
            fetch_thread_q <= fetch_thread_d;
            fetch_pc_q     <= fetch_pc_d;
        end
    end

    assign fetch_valid  = fetch_valid_q;
    assign fetch_thread = fetch_thread_q;
    assign fetch_pc     = fetch_pc_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// Bench for thread_scheduler: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_thread_scheduler;
    import common::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  thread_enable;
    logic        stall;
    logic        if_valid;
    threadid_t   if_thread;
    vptr_t       if_pc;
    logic        if_icache_miss;
    logic        if_itlb_miss;
    logic        mem_fill_en;
    threadid_t   mem_fill_thread;
    logic        wb_invalidate_en;
    threadid_t   wb_invalidate_thread;
    vptr_t       wb_redirect_pc;
    logic        fetch_valid;
    threadid_t   fetch_thread;
    vptr_t       fetch_pc;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    thread_scheduler #(
        .N_THREADS (N),
        .RESET_PC  (32'h0000_1000)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .thread_enable        (thread_enable),
        .stall                (stall),
        .if_valid             (if_valid),
        .if_thread            (if_thread),
        .if_pc                (if_pc),
        .if_icache_miss       (if_icache_miss),
        .if_itlb_miss         (if_itlb_miss),
        .mem_fill_en          (mem_fill_en),
        .mem_fill_thread      (mem_fill_thread),
        .wb_invalidate_en     (wb_invalidate_en),
        .wb_invalidate_thread (wb_invalidate_thread),
        .wb_redirect_pc       (wb_redirect_pc),
        .fetch_valid          (fetch_valid),
        .fetch_thread         (fetch_thread),
        .fetch_pc             (fetch_pc)
    );

    // Behavioural model: 0 = ready, 1 = waiting for fill, 2 = waiting for redirect.
    int          m_state [N];
    logic [31:0] m_pc    [N];
    int          m_last;
    int          m_cool;
    bit          m_v;
    int          m_t;
    logic [31:0] m_opc;

    always @(posedge clk) begin
        int pick;
        int c;
        int it, ft, wt;
        bit ev_miss;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_state[i] = 0;
                m_pc[i]    = 32'h0000_1000;
            end
            m_last = N - 1;
            m_cool = -1;
            m_v    = 1'b0;
            m_t    = 0;
            m_opc  = 32'h0;
        end else begin
            it = int'(if_thread);
            ft = int'(mem_fill_thread);
            wt = int'(wb_invalidate_thread);
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                ev_miss = if_valid && (if_icache_miss || if_itlb_miss) && (it == c);
                if (pick < 0 && m_state[c] == 0 && thread_enable[c[1:0]] && m_cool != c
                    && !ev_miss && !(wb_invalidate_en && wt == c))
                    pick = c;
            end
            if (!stall) begin
                if (pick >= 0) begin
                    m_v   = 1'b1;
                    m_t   = pick;
                    m_opc = m_pc[pick];
                    m_pc[pick] = m_pc[pick] + 32'd4;
                    m_last = pick;
                    m_cool = pick;
                end else begin
                    m_v    = 1'b0;
                    m_cool = -1;
                end
            end else if (wb_invalidate_en && m_v && wt == m_t) begin
                m_v = 1'b0;
            end
            if (mem_fill_en && m_state[ft] == 1) m_state[ft] = 0;
            if (if_valid && if_itlb_miss) begin
                m_state[it] = 2;
            end else if (if_valid && if_icache_miss) begin
                m_state[it] = 1;
                m_pc[it]    = if_pc;
            end
            if (wb_invalidate_en) begin
                m_state[wt] = 0;
                m_pc[wt]    = wb_redirect_pc;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if (fetch_valid !== m_v) begin
                bad++;
                $display("FAIL model_valid t=%0t: got %0b want %0b", $time, fetch_valid, m_v);
            end
            if (m_v) begin
                total++;
                if (int'(fetch_thread) != m_t || fetch_pc !== m_opc) begin
                    bad++;
                    $display("FAIL model_fetch t=%0t: got thread=%0d pc=%h want thread=%0d pc=%h",
                             $time, fetch_thread, fetch_pc, m_t, m_opc);
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic clr();
        if_valid = 0; if_thread = '0; if_pc = '0; if_icache_miss = 0; if_itlb_miss = 0;
        mem_fill_en = 0; mem_fill_thread = '0;
        wb_invalidate_en = 0; wb_invalidate_thread = '0; wb_redirect_pc = '0;
    endtask

    task automatic expect_out(input string name, input bit v, input int t,
                              input logic [31:0] pc, input bit all);
        total++;
        if (fetch_valid !== v || ((v || all) && (int'(fetch_thread) != t || fetch_pc !== pc))) begin
            bad++;
            $display("FAIL %s: got v=%0b thread=%0d pc=%h want v=%0b thread=%0d pc=%h",
                     name, fetch_valid, fetch_thread, fetch_pc, v, t, pc);
        end
    endtask

    task automatic do_reset(input logic [3:0] en);
        clr();
        stall = 0;
        rst = 1;
        thread_enable = en;
        cyc();
        expect_out("reset_outputs", 0, 0, 32'h0, 1);
        rst = 0;
    endtask

    initial begin
        bit          acc;
        int          at;
        logic [31:0] apc;
        int          r;

        clr();
        rst = 1; stall = 0; thread_enable = '0;
        cyc();
        chk_en = 1'b1;

        // Four threads, no misses: round robin 0..3 then 0 again with advanced PC.
        do_reset(4'hF);
        cyc(); expect_out("rr_t0", 1, 0, 32'h1000, 0);
        cyc(); expect_out("rr_t1", 1, 1, 32'h1000, 0);
        cyc(); expect_out("rr_t2", 1, 2, 32'h1000, 0);
        cyc(); expect_out("rr_t3", 1, 3, 32'h1000, 0);
        cyc(); expect_out("rr_t0b", 1, 0, 32'h1004, 0);

        // Single thread issues every other cycle.
        do_reset(4'b0100);
        cyc(); expect_out("solo_a", 1, 2, 32'h1000, 0);
        cyc(); expect_out("solo_gap1", 0, 0, 32'h0, 0);
        cyc(); expect_out("solo_b", 1, 2, 32'h1004, 0);
        cyc(); expect_out("solo_gap2", 0, 0, 32'h0, 0);
        cyc(); expect_out("solo_c", 1, 2, 32'h1008, 0);

        // Icache miss replay, fill-to-issue latency of two cycles.
        do_reset(4'b0010);
        cyc(); cyc(); cyc(); expect_out("ic_pre", 1, 1, 32'h1004, 0);
        if_valid = 1; if_thread = 2'd1; if_pc = 32'h1004; if_icache_miss = 1;
        cyc(); clr(); expect_out("ic_parked1", 0, 0, 32'h0, 0);
        cyc(); expect_out("ic_parked2", 0, 0, 32'h0, 0);
        mem_fill_en = 1; mem_fill_thread = 2'd1;
        cyc(); clr(); expect_out("ic_fill_k1", 0, 0, 32'h0, 0);
        cyc(); expect_out("ic_fill_k2", 1, 1, 32'h1004, 0);

        // ITLB miss ignores fills and waits for a redirect.
        do_reset(4'b0001);
        cyc(); expect_out("itlb_pre", 1, 0, 32'h1000, 0);
        if_valid = 1; if_thread = 2'd0; if_pc = 32'h1000; if_itlb_miss = 1;
        cyc(); clr();
        cyc();
        mem_fill_en = 1; mem_fill_thread = 2'd0;
        cyc(); clr();
        cyc(); expect_out("itlb_fill_ignored", 0, 0, 32'h0, 0);
        wb_invalidate_en = 1; wb_invalidate_thread = 2'd0; wb_redirect_pc = 32'h8000;
        cyc(); clr(); expect_out("itlb_redir_k1", 0, 0, 32'h0, 0);
        cyc(); expect_out("itlb_redir_k2", 1, 0, 32'h8000, 0);

        // Redirect overrides a simultaneous icache miss report.
        do_reset(4'b1000);
        cyc(); expect_out("ovr_pre", 1, 3, 32'h1000, 0);
        if_valid = 1; if_thread = 2'd3; if_pc = 32'h1000; if_icache_miss = 1;
        wb_invalidate_en = 1; wb_invalidate_thread = 2'd3; wb_redirect_pc = 32'h2000;
        cyc(); clr();
        cyc(); expect_out("ovr_ready", 1, 3, 32'h2000, 0);

        // PC increment wraps at 2^32.
        do_reset(4'b0001);
        wb_invalidate_en = 1; wb_invalidate_thread = 2'd0; wb_redirect_pc = 32'hFFFF_FFFC;
        cyc(); clr();
        cyc(); expect_out("wrap_a", 1, 0, 32'hFFFF_FFFC, 0);
        cyc();
        cyc(); expect_out("wrap_b", 1, 0, 32'h0000_0000, 0);

        // Stall freezes outputs; invalidating the presented thread drops fetch_valid.
        do_reset(4'b0010);
        cyc(); expect_out("stall_pre", 1, 1, 32'h1000, 0);
        stall = 1;
        cyc(); expect_out("stall_c1", 1, 1, 32'h1000, 0);
        wb_invalidate_en = 1; wb_invalidate_thread = 2'd1; wb_redirect_pc = 32'h3000;
        cyc(); clr(); expect_out("stall_c2_inval", 0, 0, 32'h0, 0);
        cyc(); expect_out("stall_c3", 0, 0, 32'h0, 0);
        stall = 0;
        do_reset(4'hF);
        cyc(); expect_out("post_rst_t0", 1, 0, 32'h1000, 0);
        cyc(); expect_out("post_rst_t1", 1, 1, 32'h1000, 0);
        cyc(); expect_out("post_rst_t2", 1, 2, 32'h1000, 0);
        cyc(); expect_out("post_rst_t3", 1, 3, 32'h1000, 0);

        // Randomized traffic against the model.
        acc = 0; at = 0; apc = '0;
        repeat (3000) begin
            clr();
            rst   = ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) thread_enable = 4'($urandom);
            if (acc) begin
                if_valid  = 1;
                if_thread = 2'(at);
                if_pc     = apc;
                r = $urandom_range(0, 9);
                if_icache_miss = (r < 2) || (r == 3);
                if_itlb_miss   = (r == 2) || (r == 3);
            end
            if ($urandom_range(0, 3) == 0) begin
                mem_fill_en = 1;
                mem_fill_thread = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 11) == 0) begin
                wb_invalidate_en = 1;
                wb_invalidate_thread = 2'($urandom_range(0, 3));
                wb_redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            end
            acc = m_v && !stall && !rst;
            at  = m_t;
            apc = m_opc;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
